// File: rtl/sr_bank_writer.sv
// rtl/sr_bank_writer.sv - S/R flip-flop bank writer with verify-and-retry sequencing
module sr_bank_writer #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Retry counter must hold 0..MAX_RETRY and stay at least one bit wide.
  localparam int CW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] C_MAX_RETRY = CW'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_target;
  logic [CW-1:0]    r_retry;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_r;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_mismatch;

  assign w_mismatch = (q_fb != r_target);

  // Sequencer: excitation is computed on the edge that enters DRIVE so that
  // s_out/r_out are registered and only ever non-zero for that one cycle.
  // Set and reset masks are disjoint by construction (target vs ~target).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_target <= '0;
      r_retry  <= '0;
      r_s      <= '0;
      r_r      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_s    <= '0;
      r_r    <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_target <= in_data;
            r_retry  <= '0;
            r_s      <= in_data & ~q_fb;
            r_r      <= ~in_data & q_fb;
            r_busy   <= 1'b1;
            r_state  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (!w_mismatch) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_retry < C_MAX_RETRY) begin
            r_retry <= r_retry + 1'b1;
            r_s     <= r_target & ~q_fb;
            r_r     <= ~r_target & q_fb;
            r_state <= ST_DRIVE;
          end else begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready = (r_state == ST_IDLE);
  assign s_out    = r_s;
  assign r_out    = r_r;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_sr_bank_writer.sv
// tb/tb_sr_bank_writer.sv - randomized self-checking bench for sr_bank_writer
module tb_sr_bank_writer;

  localparam int W  = 8;
  localparam int MR = 3;
  localparam int NC = 4 + 3 * MR + 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] s_out;
  logic [W-1:0] r_out;
  logic [W-1:0] q_fb;
  logic         busy;
  logic         done;
  logic         err;

  int vectors;
  int miscompares;

  // Bank fault model: bits in stuck_mask are pinned to stuck_val.
  logic [W-1:0] stuck_mask;
  logic [W-1:0] stuck_val;

  logic [W-1:0] cap_s [0:NC];
  logic [W-1:0] cap_r [0:NC];
  logic         cap_done [0:NC];
  logic         cap_err [0:NC];
  logic         cap_busy [0:NC];
  logic         cap_rdy [0:NC];

  logic [W-1:0] exp_s [0:NC];
  logic [W-1:0] exp_r [0:NC];
  logic         exp_done [0:NC];
  logic         exp_err [0:NC];
  logic         exp_busy [0:NC];
  logic         exp_rdy [0:NC];

  sr_bank_writer #(.WIDTH(W), .MAX_RETRY(MR)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .s_out    (s_out),
    .r_out    (r_out),
    .q_fb     (q_fb),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] bank_next(input logic [W-1:0] q, input logic [W-1:0] s,
                                             input logic [W-1:0] r, input logic [W-1:0] m,
                                             input logic [W-1:0] v);
    return (((q & ~r) | s) & ~m) | (v & m);
  endfunction

  // One cycle: the bank reacts to excitation mid-cycle, outputs are sampled 1ns after the edge.
  task automatic tick();
    @(negedge clk);
    q_fb = bank_next(q_fb, s_out, r_out, stuck_mask, stuck_val);
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int c);
    cap_s[c]    = s_out;
    cap_r[c]    = r_out;
    cap_done[c] = done;
    cap_err[c]  = err;
    cap_busy[c] = busy;
    cap_rdy[c]  = in_ready;
  endtask

  // Present one write for a single cycle, then record NC further cycles with junk data.
  task automatic capture(input logic [W-1:0] t);
    in_valid = 1'b1;
    in_data  = t;
    sample(0);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= NC; c++) begin
      in_data = W'($urandom);
      sample(c);
      if (c < NC) tick();
    end
  endtask

  // Reference: each attempt excites target-vs-current differences, the bank settles,
  // then the result is judged; attempts are 3 cycles apart starting at cycle 1.
  task automatic predict(input logic [W-1:0] t, input logic [W-1:0] q0);
    logic [W-1:0] q;
    logic [W-1:0] s;
    logic [W-1:0] r;
    int fin;
    for (int c = 0; c <= NC; c++) begin
      exp_s[c] = '0; exp_r[c] = '0; exp_done[c] = 1'b0; exp_err[c] = 1'b0; exp_busy[c] = 1'b0;
    end
    q = q0;
    fin = 4 + 3 * MR;
    for (int k = 0; k <= MR; k++) begin
      s = t & ~q;
      r = ~t & q;
      exp_s[1 + 3 * k] = s;
      exp_r[1 + 3 * k] = r;
      q = bank_next(q, s, r, stuck_mask, stuck_val);
      if (q == t) begin
        fin = 4 + 3 * k;
        exp_done[fin] = 1'b1;
        break;
      end else if (k == MR) begin
        exp_err[fin] = 1'b1;
      end
    end
    for (int c = 1; c < fin; c++) exp_busy[c] = 1'b1;
    for (int c = 0; c <= NC; c++) exp_rdy[c] = !exp_busy[c];
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    vectors++; if (s_out !== 8'h00) begin miscompares++; $display("FAIL reset_s_out: got %h expected 00", s_out); end
    vectors++; if (r_out !== 8'h00) begin miscompares++; $display("FAIL reset_r_out: got %h expected 00", r_out); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
    tick();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_idle_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_set_reset();
    stuck_mask = '0; stuck_val = '0;
    q_fb = 8'h0F;
    capture(8'hF0);
    vectors++; if (cap_s[1] !== 8'hF0) begin miscompares++; $display("FAIL sr_s_c1: got %h expected f0", cap_s[1]); end
    vectors++; if (cap_r[1] !== 8'h0F) begin miscompares++; $display("FAIL sr_r_c1: got %h expected 0f", cap_r[1]); end
    vectors++; if (cap_s[2] !== 8'h00 || cap_r[2] !== 8'h00) begin miscompares++; $display("FAIL sr_c2_zero: got s=%h r=%h expected 00", cap_s[2], cap_r[2]); end
    for (int c = 0; c <= NC; c++) begin
      vectors++; if (cap_done[c] !== (c == 4)) begin miscompares++; $display("FAIL sr_done cycle %0d: got %b expected %b", c, cap_done[c], (c == 4)); end
      vectors++; if (cap_err[c] !== 1'b0) begin miscompares++; $display("FAIL sr_err cycle %0d: got %b expected 0", c, cap_err[c]); end
    end
    vectors++; if (q_fb !== 8'hF0) begin miscompares++; $display("FAIL sr_bank: got %h expected f0", q_fb); end
  endtask

  task automatic test_match();
    q_fb = 8'h5A;
    capture(8'h5A);
    vectors++; if (cap_s[1] !== 8'h00 || cap_r[1] !== 8'h00) begin miscompares++; $display("FAIL match_c1: got s=%h r=%h expected 00", cap_s[1], cap_r[1]); end
    vectors++; if (cap_busy[1] !== 1'b1) begin miscompares++; $display("FAIL match_busy_c1: got %b expected 1", cap_busy[1]); end
    for (int c = 0; c <= NC; c++) begin
      vectors++; if (cap_done[c] !== (c == 4)) begin miscompares++; $display("FAIL match_done cycle %0d: got %b expected %b", c, cap_done[c], (c == 4)); end
      vectors++; if (cap_err[c] !== 1'b0) begin miscompares++; $display("FAIL match_err cycle %0d: got %b expected 0", c, cap_err[c]); end
    end
  endtask

  task automatic test_stuck();
    logic exp_hit;
    stuck_mask = 8'hFF; stuck_val = 8'h00;
    q_fb = 8'h00;
    capture(8'h01);
    for (int c = 0; c <= NC; c++) begin
      exp_hit = (c == 1) || (c == 4) || (c == 7) || (c == 10);
      vectors++; if (cap_s[c] !== (exp_hit ? 8'h01 : 8'h00)) begin miscompares++; $display("FAIL stuck_s cycle %0d: got %h expected %h", c, cap_s[c], (exp_hit ? 8'h01 : 8'h00)); end
      vectors++; if (cap_r[c] !== 8'h00) begin miscompares++; $display("FAIL stuck_r cycle %0d: got %h expected 00", c, cap_r[c]); end
      vectors++; if (cap_err[c] !== (c == 13)) begin miscompares++; $display("FAIL stuck_err cycle %0d: got %b expected %b", c, cap_err[c], (c == 13)); end
      vectors++; if (cap_done[c] !== 1'b0) begin miscompares++; $display("FAIL stuck_done cycle %0d: got %b expected 0", c, cap_done[c]); end
    end
    stuck_mask = '0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] t2;
    q_fb = W'($urandom);
    in_valid = 1'b1; in_data = ~q_fb;
    tick();
    in_valid = 1'b0;
    tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_wait: got %b expected 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b expected 0", busy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready: got %b expected 1", in_ready); end
    vectors++; if (s_out !== 8'h00 || r_out !== 8'h00) begin miscompares++; $display("FAIL mid_sr: got s=%h r=%h expected 00", s_out, r_out); end
    for (int c = 0; c < 5; c++) begin
      vectors++; if (done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL mid_pulse step %0d: got done=%b err=%b expected 0", c, done, err); end
      tick();
    end
    t2 = W'($urandom);
    capture(t2);
    for (int c = 0; c <= NC; c++) begin
      vectors++; if (cap_done[c] !== (c == 4)) begin miscompares++; $display("FAIL mid_new_done cycle %0d: got %b expected %b", c, cap_done[c], (c == 4)); end
    end
    vectors++; if (q_fb !== t2) begin miscompares++; $display("FAIL mid_new_bank: got %h expected %h", q_fb, t2); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q0;
    q0 = W'($urandom);
    q_fb = q0;
    in_valid = 1'b1; in_data = 8'h33;
    for (int c = 0; c <= 9; c++) begin
      sample(c);
      if (c == 5) in_valid = 1'b0;
      tick();
      if (c == 0) in_data = 8'hCC;
    end
    vectors++; if (cap_s[1] !== (8'h33 & ~q0) || cap_r[1] !== (8'hCC & q0)) begin miscompares++; $display("FAIL b2b_first_sr: got s=%h r=%h expected s=%h r=%h", cap_s[1], cap_r[1], 8'h33 & ~q0, 8'hCC & q0); end
    vectors++; if (cap_done[4] !== 1'b1 || cap_rdy[4] !== 1'b1) begin miscompares++; $display("FAIL b2b_c4: got done=%b ready=%b expected 1 1", cap_done[4], cap_rdy[4]); end
    vectors++; if (cap_s[5] !== 8'hCC || cap_r[5] !== 8'h33) begin miscompares++; $display("FAIL b2b_second_sr: got s=%h r=%h expected s=cc r=33", cap_s[5], cap_r[5]); end
    vectors++; if (cap_busy[5] !== 1'b1 || cap_rdy[5] !== 1'b0) begin miscompares++; $display("FAIL b2b_c5_busy: got busy=%b ready=%b expected 1 0", cap_busy[5], cap_rdy[5]); end
    vectors++; if (cap_done[8] !== 1'b1) begin miscompares++; $display("FAIL b2b_done2: got %b expected 1", cap_done[8]); end
    vectors++; if (cap_busy[9] !== 1'b0 || cap_done[9] !== 1'b0) begin miscompares++; $display("FAIL b2b_c9: got busy=%b done=%b expected 0 0", cap_busy[9], cap_done[9]); end
    for (int c = 0; c <= 9; c++) begin
      vectors++; if ((cap_s[c] & cap_r[c]) !== 8'h00) begin miscompares++; $display("FAIL b2b_overlap cycle %0d: got %h expected 00", c, cap_s[c] & cap_r[c]); end
    end
    vectors++; if (q_fb !== 8'hCC) begin miscompares++; $display("FAIL b2b_bank: got %h expected cc", q_fb); end
  endtask

  task automatic test_random();
    logic [W-1:0] t;
    for (int it = 0; it < 30; it++) begin
      stuck_mask = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      stuck_val  = W'($urandom);
      q_fb = (W'($urandom) & ~stuck_mask) | (stuck_val & stuck_mask);
      t = W'($urandom);
      predict(t, q_fb);
      capture(t);
      for (int c = 0; c <= NC; c++) begin
        vectors++; if (cap_s[c] !== exp_s[c]) begin miscompares++; $display("FAIL rand_s it %0d cycle %0d: got %h expected %h", it, c, cap_s[c], exp_s[c]); end
        vectors++; if (cap_r[c] !== exp_r[c]) begin miscompares++; $display("FAIL rand_r it %0d cycle %0d: got %h expected %h", it, c, cap_r[c], exp_r[c]); end
        vectors++; if (cap_done[c] !== exp_done[c]) begin miscompares++; $display("FAIL rand_done it %0d cycle %0d: got %b expected %b", it, c, cap_done[c], exp_done[c]); end
        vectors++; if (cap_err[c] !== exp_err[c]) begin miscompares++; $display("FAIL rand_err it %0d cycle %0d: got %b expected %b", it, c, cap_err[c], exp_err[c]); end
        vectors++; if (cap_busy[c] !== exp_busy[c]) begin miscompares++; $display("FAIL rand_busy it %0d cycle %0d: got %b expected %b", it, c, cap_busy[c], exp_busy[c]); end
        vectors++; if (cap_rdy[c] !== exp_rdy[c]) begin miscompares++; $display("FAIL rand_ready it %0d cycle %0d: got %b expected %b", it, c, cap_rdy[c], exp_rdy[c]); end
      end
    end
    stuck_mask = '0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    stuck_mask = '0;
    stuck_val = '0;
    q_fb = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    test_reset();
    test_set_reset();
    test_match();
    test_stuck();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/sr_bank_writer.md
SR_BANK_WRITER -- requirements
Module: sr_bank_writer

Interface
REQ-001 Parameter WIDTH, default 8, number of S/R flip-flop bits driven.
REQ-002 Parameter MAX_RETRY, default 3, extra drive attempts after a failed check; 0 is legal.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  write request carrying in_data.
REQ-006 in_ready  output  1  high only in IDLE; transfer occurs on edge with in_valid && in_ready.
REQ-007 in_data  input  WIDTH  target word; sampled only at transfer.
REQ-008 s_out  output  WIDTH  registered Set excitation to flip-flop bank.
REQ-009 r_out  output  WIDTH  registered Reset excitation to flip-flop bank.
REQ-010 q_fb  input  WIDTH  Q outputs fed back from the bank.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse: bank matches target.
REQ-013 err  output  1  one-cycle pulse: retries exhausted without match.

Function
REQ-014 FSM states IDLE, DRIVE, WAIT, CHECK; exactly one active.
REQ-015 IDLE: on transfer, latch in_data into target, clear retry count, go DRIVE.
REQ-016 Entering DRIVE, s_out <= target & ~q_fb and r_out <= ~target & q_fb, using q_fb sampled at that edge.
REQ-017 s_out/r_out nonzero only during the single DRIVE cycle; zero in every other state.
REQ-018 s_out & r_out SHALL be 0 on every cycle (never request the invalid S=R=1 condition).
REQ-019 Bits where target equals q_fb receive S=0,R=0 (hold); if all bits match, DRIVE still occurs with zero excitation.
REQ-020 DRIVE -> WAIT unconditionally; WAIT -> CHECK unconditionally (one settle cycle for bank Q update).
REQ-021 CHECK: q_fb == target -> done pulse, go IDLE.
REQ-022 CHECK: mismatch and retry count < MAX_RETRY -> increment count, go DRIVE (re-excite from current q_fb).
REQ-023 CHECK: mismatch and retry count == MAX_RETRY -> err pulse, go IDLE.
REQ-024 done/err registered, asserted in the first IDLE cycle after CHECK, high exactly one cycle, never together.
REQ-025 Latency: transfer edge = cycle 0; first DRIVE cycle 1; done on cycle 4 if first check passes; each retry adds 3 cycles; err on cycle 4+3*MAX_RETRY.
REQ-026 Retry counter width clog2(MAX_RETRY+1), minimum 1; never wraps.
REQ-027 in_valid and in_data ignored while busy; a request held across busy is accepted in the done/err cycle (in_ready=1 then).
REQ-028 q_fb changes outside DRIVE entry and CHECK do not affect behaviour.

Reset
REQ-029 rst high at an edge: state IDLE, s_out=0, r_out=0, done=0, err=0, busy=0, target and retry count cleared; takes priority over all other activity.
REQ-030 Reset mid-operation abandons the write with no done/err pulse; in_ready=1 the cycle after rst deasserts at an edge.

Verification
REQ-031 rst high 2 cycles then low -> s_out=0x00, r_out=0x00, in_ready=1, busy=0, done=err=0.
REQ-032 WIDTH=8, bank model with q_fb=0x0F, write 0xF0 -> cycle 1 s_out=0xF0, r_out=0x0F; cycle 2 both 0x00; done=1 on cycle 4 only; q_fb=0xF0.
REQ-033 q_fb=0x5A, write 0x5A -> cycle 1 s_out=r_out=0x00; done on cycle 4; err never asserts.
REQ-034 q_fb stuck 0x00, write 0x01, MAX_RETRY=3 -> s_out=0x01 on cycles 1,4,7,10; err=1 on cycle 13; done never asserts.
REQ-035 rst asserted during WAIT -> next cycle IDLE, s_out=r_out=0, no done/err pulse; a new write then completes normally.
REQ-036 in_valid held high with 0x33 then 0xCC across busy -> second word accepted on the done cycle of the first; every cycle satisfies s_out & r_out == 0.
